// File: rtl/cv32e40p_tracer_pkg.sv
// Shared definitions for the tracer and the retirement-class profiler.
package cv32e40p_tracer_pkg;

    localparam int unsigned INSTR_W = 32;

    // One programmable class: the entry hits when enabled and the masked word equals match.
    typedef struct packed {
        logic               en;
        logic [INSTR_W-1:0] mask;
        logic [INSTR_W-1:0] match;
    } class_entry_t;

    // Default classes, equivalent to the tracer INSTR_* decode patterns.
    localparam class_entry_t CLASS_LOAD   = '{en: 1'b1, mask: 32'h0000_007F, match: 32'h0000_0003};
    localparam class_entry_t CLASS_STORE  = '{en: 1'b1, mask: 32'h0000_007F, match: 32'h0000_0023};
    localparam class_entry_t CLASS_BRANCH = '{en: 1'b1, mask: 32'h0000_007F, match: 32'h0000_0063};
    localparam class_entry_t CLASS_MULDIV = '{en: 1'b1, mask: 32'hFE00_007F, match: 32'h0200_0033};
    localparam class_entry_t CLASS_FP     = '{en: 1'b1, mask: 32'h0000_007F, match: 32'h0000_0053};
    localparam class_entry_t CLASS_CUSTOM = '{en: 1'b1, mask: 32'h0000_007F, match: 32'h0000_000B};

    // Class hit test shared by the RTL compare stage and software models.
    function automatic logic class_hit(input class_entry_t e, input logic [INSTR_W-1:0] instr);
        return e.en && ((instr & e.mask) == e.match);
    endfunction

endpackage

// File: rtl/cv32e40p_trace_class_cnt.sv
// Single event counter with clear, wrap/saturate and sticky overflow.
module cv32e40p_trace_class_cnt #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter bit          SATURATE  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cnt_nxt_c,
    output logic                 ovf
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 ovf_nxt;

    // Next value: clear beats increment; all-ones + 1 wraps or holds and flags overflow.
    always_comb begin
        cnt_nxt_c = cnt_q;
        ovf_nxt   = ovf;
        if (clear) begin
            cnt_nxt_c = '0;
            ovf_nxt   = 1'b0;
        end else if (inc) begin
            if (&cnt_q) begin
                ovf_nxt   = 1'b1;
                cnt_nxt_c = SATURATE ? cnt_q : '0;
            end else begin
                cnt_nxt_c = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Counter and overflow state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ovf   <= 1'b0;
        end else begin
            cnt_q <= cnt_nxt_c;
            ovf   <= ovf_nxt;
        end
    end

endmodule

// File: rtl/cv32e40p_trace_class_counter.sv
// Retirement-class profiler: programmable mask/match classes with per-class counters.
module cv32e40p_trace_class_counter
    import cv32e40p_tracer_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = 8,
    parameter int unsigned CNT_WIDTH   = 32,
    parameter bit          SATURATE    = 1'b0,
    parameter bit          MULTI_MATCH = 1'b0,
    localparam int unsigned IDX_W      = $clog2(NUM_CLASSES + 1),
    localparam int unsigned CFG_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   retire_valid_i,
    input  logic [31:0]            retire_instr_i,
    input  logic                   freeze_i,
    input  logic                   clear_i,
    input  logic                   cfg_we_i,
    input  logic [CFG_W-1:0]       cfg_idx_i,
    input  logic                   cfg_en_i,
    input  logic [31:0]            cfg_mask_i,
    input  logic [31:0]            cfg_match_i,
    input  logic                   rd_req_i,
    input  logic [IDX_W-1:0]       rd_idx_i,
    output logic                   rd_valid_o,
    output logic [CNT_WIDTH-1:0]   rd_data_o,
    output logic [NUM_CLASSES:0]   ovf_o
);

    localparam int unsigned NCNT = NUM_CLASSES + 1;

    logic                 s1_valid;
    logic [31:0]          s1_instr;
    class_entry_t         table_q [NUM_CLASSES];
    logic [NUM_CLASSES-1:0] hit;
    logic [NUM_CLASSES-1:0] inc_cls;
    logic                 inc_unm;
    logic                 found;
    logic [NCNT-1:0]      inc_vec;
    logic [CNT_WIDTH-1:0] cnt_nxt [NCNT];

    // Stage 1: capture retired word; frozen retires never enter the pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_instr <= '0;
        end else begin
            s1_valid <= retire_valid_i && !freeze_i;
            s1_instr <= retire_instr_i;
        end
    end

    // Class table write port; stage 2 sees the new entry only after this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_CLASSES); i++) begin
                table_q[i] <= '0;
            end
        end else if (cfg_we_i && (32'(cfg_idx_i) < NUM_CLASSES)) begin
            table_q[cfg_idx_i] <= '{en: cfg_en_i, mask: cfg_mask_i, match: cfg_match_i};
        end
    end

    // Stage 2 compare of the stage-1 word against every table entry.
    always_comb begin
        hit = '0;
        for (int i = 0; i < int'(NUM_CLASSES); i++) begin
            hit[i] = s1_valid && class_hit(table_q[i], s1_instr);
        end
    end

    // Increment selection: all hits, or only the lowest-index hit; no hit goes to unmatched.
    always_comb begin
        inc_cls = '0;
        found   = 1'b0;
        if (MULTI_MATCH) begin
            inc_cls = hit;
        end else begin
            for (int i = 0; i < int'(NUM_CLASSES); i++) begin
                if (hit[i] && !found) begin
                    inc_cls[i] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
        inc_unm = s1_valid && (hit == '0);
        inc_vec = {inc_unm, inc_cls};
    end

    // Per-class counters plus the unmatched counter at index NUM_CLASSES.
    for (genvar g = 0; g < NCNT; g++) begin : g_cnt
        cv32e40p_trace_class_cnt #(
            .CNT_WIDTH (CNT_WIDTH),
            .SATURATE  (SATURATE)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .clear     (clear_i),
            .inc       (inc_vec[g]),
            .cnt_nxt_c (cnt_nxt[g]),
            .ovf       (ovf_o[g])
        );
    end

    // Read port returns the counter value as of the end of the request cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            rd_valid_o <= rd_req_i;
            if (rd_req_i) begin
                rd_data_o <= (32'(rd_idx_i) < NCNT) ? cnt_nxt[rd_idx_i] : '0;
            end
        end
    end

endmodule

// File: tb/tb_cv32e40p_trace_class_counter.sv
// Scoreboard bench: three configurations driven in lockstep, reads checked by a monitor.
module tb_cv32e40p_trace_class_counter;

    logic        clk;
    logic        rst;
    logic        retire_valid;
    logic [31:0] retire_instr;
    logic        freeze;
    logic        clear;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic        cfg_en;
    logic [31:0] cfg_mask;
    logic [31:0] cfg_match;
    logic        rd_req;
    logic [3:0]  rd_idx;

    logic        rd_valid_a, rd_valid_b, rd_valid_c;
    logic [31:0] rd_data_a;
    logic [7:0]  rd_data_b, rd_data_c;
    logic [8:0]  ovf_a, ovf_b, ovf_c;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] ea;
        logic [7:0]  eb;
        logic [7:0]  ec;
        logic [8:0]  oa;
        logic [8:0]  ob;
        logic [8:0]  oc;
    } exp_t;

    exp_t sbq[$];

    localparam logic [8:0] Z = 9'h000;

    // A: 32-bit wrap, lowest-index priority
    cv32e40p_trace_class_counter u_dut_a (
        .clk(clk), .rst(rst), .retire_valid_i(retire_valid), .retire_instr_i(retire_instr),
        .freeze_i(freeze), .clear_i(clear), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx),
        .cfg_en_i(cfg_en), .cfg_mask_i(cfg_mask), .cfg_match_i(cfg_match),
        .rd_req_i(rd_req), .rd_idx_i(rd_idx), .rd_valid_o(rd_valid_a),
        .rd_data_o(rd_data_a), .ovf_o(ovf_a));

    // B: 8-bit wrap, multi-match
    cv32e40p_trace_class_counter #(.CNT_WIDTH(8), .SATURATE(1'b0), .MULTI_MATCH(1'b1)) u_dut_b (
        .clk(clk), .rst(rst), .retire_valid_i(retire_valid), .retire_instr_i(retire_instr),
        .freeze_i(freeze), .clear_i(clear), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx),
        .cfg_en_i(cfg_en), .cfg_mask_i(cfg_mask), .cfg_match_i(cfg_match),
        .rd_req_i(rd_req), .rd_idx_i(rd_idx), .rd_valid_o(rd_valid_b),
        .rd_data_o(rd_data_b), .ovf_o(ovf_b));

    // C: 8-bit saturate, lowest-index priority
    cv32e40p_trace_class_counter #(.CNT_WIDTH(8), .SATURATE(1'b1), .MULTI_MATCH(1'b0)) u_dut_c (
        .clk(clk), .rst(rst), .retire_valid_i(retire_valid), .retire_instr_i(retire_instr),
        .freeze_i(freeze), .clear_i(clear), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx),
        .cfg_en_i(cfg_en), .cfg_mask_i(cfg_mask), .cfg_match_i(cfg_match),
        .rd_req_i(rd_req), .rd_idx_i(rd_idx), .rd_valid_o(rd_valid_c),
        .rd_data_o(rd_data_c), .ovf_o(ovf_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic retire(input logic [31:0] ins, input logic frz, input int n);
        repeat (n) begin
            retire_valid = 1'b1;
            retire_instr = ins;
            freeze       = frz;
            @(negedge clk);
        end
        retire_valid = 1'b0;
        freeze       = 1'b0;
    endtask

    task automatic cfg(input logic [2:0] idx, input logic en, input logic [31:0] m, input logic [31:0] v);
        cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_mask = m; cfg_match = v;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Queue the expectation and raise the request for the current cycle.
    task automatic rd_push(input logic [3:0] idx, input logic [31:0] ea, input logic [7:0] eb,
                           input logic [7:0] ec, input logic [8:0] oa, input logic [8:0] ob,
                           input logic [8:0] oc);
        sbq.push_back('{idx: idx, ea: ea, eb: eb, ec: ec, oa: oa, ob: ob, oc: oc});
        rd_req = 1'b1;
        rd_idx = idx;
    endtask

    task automatic read1(input logic [3:0] idx, input logic [31:0] ea, input logic [7:0] eb,
                         input logic [7:0] ec, input logic [8:0] oa, input logic [8:0] ob,
                         input logic [8:0] oc);
        rd_push(idx, ea, eb, ec, oa, ob, oc);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    // Monitor: every read response is matched against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (rd_valid_a || rd_valid_b || rd_valid_c)) begin
                if (sbq.size() == 0 || !(rd_valid_a && rd_valid_b && rd_valid_c)) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rd_valid: got a=%0b b=%0b c=%0b with %0d queued",
                             rd_valid_a, rd_valid_b, rd_valid_c, sbq.size());
                end else begin
                    e = sbq.pop_front();
                    chk($sformatf("rd_a[%0d]", e.idx), 64'(rd_data_a), 64'(e.ea));
                    chk($sformatf("rd_b[%0d]", e.idx), 64'(rd_data_b), 64'(e.eb));
                    chk($sformatf("rd_c[%0d]", e.idx), 64'(rd_data_c), 64'(e.ec));
                    chk($sformatf("ovf_a@%0d", e.idx), 64'(ovf_a), 64'(e.oa));
                    chk($sformatf("ovf_b@%0d", e.idx), 64'(ovf_b), 64'(e.ob));
                    chk($sformatf("ovf_c@%0d", e.idx), 64'(ovf_c), 64'(e.oc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; retire_valid = 1'b0; retire_instr = '0; freeze = 1'b0; clear = 1'b0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_mask = '0; cfg_match = '0;
        rd_req = 1'b0; rd_idx = '0;
        tick(3);
        rst = 1'b0;

        // Reset state
        chk("rst_rd_valid", 64'({rd_valid_a, rd_valid_b, rd_valid_c}), 64'(0));
        chk("rst_rd_data", 64'({rd_data_a, rd_data_b, rd_data_c}), 64'(0));
        chk("rst_ovf", 64'({ovf_a, ovf_b, ovf_c}), 64'(0));

        // R-type class, five back-to-back retires
        cfg(3'd0, 1'b1, 32'h7F, 32'h33);
        retire(32'h00B5_0533, 1'b0, 5);
        read1(4'd0, 32'd5, 8'd5, 8'd5, Z, Z, Z);
        read1(4'd8, 32'd0, 8'd0, 8'd0, Z, Z, Z);
        read1(4'd9, 32'd0, 8'd0, 8'd0, Z, Z, Z);
        read1(4'd15, 32'd0, 8'd0, 8'd0, Z, Z, Z);

        // Overlapping entries: priority vs multi-match
        cfg(3'd0, 1'b1, 32'h7F, 32'h13);
        cfg(3'd1, 1'b1, 32'h707F, 32'h13);
        do_clear();
        retire(32'h0000_0013, 1'b0, 1);
        read1(4'd0, 32'd1, 8'd1, 8'd1, Z, Z, Z);
        read1(4'd1, 32'd0, 8'd1, 8'd0, Z, Z, Z);
        read1(4'd8, 32'd0, 8'd0, 8'd0, Z, Z, Z);

        // 8-bit boundary: wrap vs saturate, sticky overflow
        cfg(3'd1, 1'b0, 32'h0, 32'h0);
        do_clear();
        retire(32'h0000_0013, 1'b0, 255);
        read1(4'd0, 32'd255, 8'd255, 8'd255, Z, Z, Z);
        retire(32'h0000_0013, 1'b0, 1);
        read1(4'd0, 32'd256, 8'd0, 8'd255, Z, 9'h001, 9'h001);
        retire(32'h0000_0013, 1'b0, 1);
        read1(4'd0, 32'd257, 8'd1, 8'd255, Z, 9'h001, 9'h001);

        // Clear collides with a stage-2 increment; stage-1 word survives
        do_clear();
        retire(32'h0000_0013, 1'b0, 4);
        retire_valid = 1'b1; retire_instr = 32'h0000_0013; clear = 1'b1;
        rd_push(4'd0, 32'd0, 8'd0, 8'd0, Z, Z, Z);
        tick(1);
        retire_valid = 1'b0; clear = 1'b0;
        rd_push(4'd0, 32'd1, 8'd1, 8'd1, Z, Z, Z);
        tick(1);
        rd_req = 1'b0;

        // Freeze, then table rewrite in the middle of a stream
        do_clear();
        retire(32'h0000_0013, 1'b1, 4);
        retire(32'h0000_0013, 1'b0, 2);
        read1(4'd0, 32'd2, 8'd2, 8'd2, Z, Z, Z);
        retire(32'h0000_0033, 1'b0, 1);
        retire_valid = 1'b1; retire_instr = 32'h0000_0033;
        cfg(3'd0, 1'b1, 32'h0, 32'h0);
        retire(32'h0000_0033, 1'b0, 2);
        read1(4'd0, 32'd5, 8'd5, 8'd5, Z, Z, Z);
        read1(4'd8, 32'd1, 8'd1, 8'd1, Z, Z, Z);

        // Synchronous reset mid-run with work in flight
        retire(32'h0000_0013, 1'b0, 10);
        rst = 1'b1; retire_valid = 1'b1; retire_instr = 32'h0000_0013;
        tick(1);
        rst = 1'b0; retire_valid = 1'b0;
        chk("rst2_rd_valid", 64'({rd_valid_a, rd_valid_b, rd_valid_c}), 64'(0));
        chk("rst2_rd_data", 64'({rd_data_a, rd_data_b, rd_data_c}), 64'(0));
        chk("rst2_ovf", 64'({ovf_a, ovf_b, ovf_c}), 64'(0));
        retire(32'h0000_0013, 1'b0, 1);
        read1(4'd8, 32'd1, 8'd1, 8'd1, Z, Z, Z);
        read1(4'd0, 32'd0, 8'd0, 8'd0, Z, Z, Z);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && sbq.size() != 0; i++) tick(1);
        tick(2);
        n_vec++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending expected 0", sbq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
